adsr_pixel_filter: RTL and testbench



---
 rtl/adsr_pkg.sv | 34 +++
 rtl/adsr_envelope.sv | 136 +++++++++++++
 rtl/adsr_pixel_filter.sv | 129 ++++++++++++
 tb/tb_adsr_pixel_filter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/adsr_pkg.sv
// -----------------------------------------------------------------------------
// adsr_pkg
// Shared types and constants for the ADSR pixel filter:
//   adsr_state_t   - envelope phase
//   TICK_CYCLES    - default clock cycles per 4 ms envelope tick (50 MHz clock)
//   BEAT_THRESH    - beat accumulator threshold (60 s / 4 ms = 15000 ticks/min)
//   CENTER_X/Y     - screen centre used by the radial mode
//   manhattan_dist - |x-CENTER_X| + |y-CENTER_Y|
// -----------------------------------------------------------------------------
package adsr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } adsr_state_t;

   localparam int TICK_CYCLES = 200_000;
   localparam int BEAT_THRESH = 15_000;
   localparam int CENTER_X    = 320;
   localparam int CENTER_Y    = 240;

   // Distance from screen centre; 320 + 240 = 560 fits in 11 bits.
   function automatic logic [10:0] manhattan_dist(input logic [9:0] x, input logic [8:0] y);
      logic [9:0] dx;
      logic [8:0] dy;
      dx = (x >= 10'(CENTER_X)) ? (x - 10'(CENTER_X)) : (10'(CENTER_X) - x);
      dy = (y >= 9'(CENTER_Y)) ? (y - 9'(CENTER_Y)) : (9'(CENTER_Y) - y);
      return {1'b0, dx} + {2'b00, dy};
   endfunction

endpackage

// File: rtl/adsr_envelope.sv
// -----------------------------------------------------------------------------
// adsr_envelope
// 4 ms tick generator, BPM beat accumulator and ADSR envelope state machine.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   enable      - 0 holds the envelope in IDLE with zero gain
//   bpm         - beats per minute; a beat fires each time the accumulator
//                 crosses BEAT_THRESH
//   env_gain    - envelope value, updated only on ticks
//   tick_4ms    - one-cycle pulse every TICK_N cycles
// -----------------------------------------------------------------------------
module adsr_envelope
   import adsr_pkg::*;
#(
   parameter int BITS          = 8,
   parameter int TICK_N        = TICK_CYCLES,
   parameter int ATTACK_STEP   = 32,
   parameter int DECAY_STEP    = 8,
   parameter int SUSTAIN_LEVEL = 128,
   parameter int SUSTAIN_TICKS = 10,
   parameter int RELEASE_STEP  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic [7:0]      bpm,
   output logic [BITS-1:0] env_gain,
   output logic            tick_4ms
);

   localparam int CNT_W = (TICK_N > 1) ? $clog2(TICK_N) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_N - 1);
   localparam logic [BITS-1:0]  GAIN_MAX  = {BITS{1'b1}};

   adsr_state_t       state_r;
   logic [CNT_W-1:0]  tick_cnt_r;
   logic [13:0]       beat_acc_r;
   logic [7:0]        adsr_counter_r;
   logic [14:0]       acc_sum_s;
   logic [14:0]       acc_next_s;
   logic              beat_s;
   logic [BITS:0]     attack_sum_s;
   logic [BITS-1:0]   attack_next_s;
   logic [BITS-1:0]   decay_next_s;
   logic [BITS-1:0]   release_next_s;

   // Beat detection and the saturating/floored next envelope values
   always_comb begin
      acc_sum_s = {1'b0, beat_acc_r} + {7'd0, bpm};
      beat_s    = tick_4ms && (acc_sum_s >= 15'(BEAT_THRESH));
      if (beat_s) begin
         acc_next_s = acc_sum_s - 15'(BEAT_THRESH);
      end else begin
         acc_next_s = acc_sum_s;
      end
      attack_sum_s  = {1'b0, env_gain} + (BITS+1)'(ATTACK_STEP);
      attack_next_s = attack_sum_s[BITS] ? GAIN_MAX : attack_sum_s[BITS-1:0];
      if ({1'b0, env_gain} >= (BITS+1)'(SUSTAIN_LEVEL + DECAY_STEP)) begin
         decay_next_s = env_gain - BITS'(DECAY_STEP);
      end else begin
         decay_next_s = BITS'(SUSTAIN_LEVEL);
      end
      if (env_gain > BITS'(RELEASE_STEP)) begin
         release_next_s = env_gain - BITS'(RELEASE_STEP);
      end else begin
         release_next_s = {BITS{1'b0}};
      end
   end

   // Tick counter and beat accumulator (accumulator is kept across BPM changes)
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_r <= {CNT_W{1'b0}};
         tick_4ms   <= 1'b0;
         beat_acc_r <= 14'd0;
      end else begin
         if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= {CNT_W{1'b0}};
            tick_4ms   <= 1'b1;
         end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
            tick_4ms   <= 1'b0;
         end
         if (tick_4ms) begin
            beat_acc_r <= 14'(acc_next_s);
         end
      end
   end

   // Envelope FSM; a beat restarts ATTACK from the current gain
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         state_r        <= ST_IDLE;
         env_gain       <= {BITS{1'b0}};
         adsr_counter_r <= 8'd0;
      end else if (beat_s) begin
         state_r <= ST_ATTACK;
      end else if (tick_4ms) begin
         case (state_r)
            ST_IDLE: begin
               env_gain <= {BITS{1'b0}};
            end
            ST_ATTACK: begin
               env_gain <= attack_next_s;
               if (attack_next_s == GAIN_MAX) begin
                  state_r <= ST_DECAY;
               end
            end
            ST_DECAY: begin
               env_gain <= decay_next_s;
               if (decay_next_s == BITS'(SUSTAIN_LEVEL)) begin
                  state_r        <= ST_SUSTAIN;
                  adsr_counter_r <= 8'd0;
               end
            end
            ST_SUSTAIN: begin
               adsr_counter_r <= adsr_counter_r + 8'd1;
               if ((adsr_counter_r + 8'd1) == 8'(SUSTAIN_TICKS)) begin
                  state_r <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               env_gain <= release_next_s;
               if (release_next_s == {BITS{1'b0}}) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               env_gain <= {BITS{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: rtl/adsr_pixel_filter.sv
// -----------------------------------------------------------------------------
// adsr_pixel_filter
// Streaming pixel brightness filter modulated by a heartbeat-driven ADSR
// envelope, with an optional radial mode centred on (320,240).
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   pix_in/valid_in            - upstream pixel; accepted when module_ready
//   module_ready               - output_ready || !valid_out
//   pix_out/valid_out/output_ready - registered downstream handshake
//   pixel_x/pixel_y            - pixel coordinates for radial mode
//   filter_enable              - 0 passes pixels through, envelope held idle
//   filter_mode                - 0 full frame, 1 radial falloff
//   BPM_estimate, pulse_amplitude - beat rate and envelope scale
//   bpm_brightness_gain, env_brightness_gain, bpm_brightness_mult,
//   brightness_gain            - combinational gain terms
// -----------------------------------------------------------------------------
module adsr_pixel_filter
   import adsr_pkg::*;
#(
   parameter int BITS          = 8,
   parameter int CLK_HZ        = 50_000_000,
   parameter int ATTACK_STEP   = 32,
   parameter int DECAY_STEP    = 8,
   parameter int SUSTAIN_LEVEL = 128,
   parameter int SUSTAIN_TICKS = 10,
   parameter int RELEASE_STEP  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BITS-1:0]   pix_in,
   input  logic              valid_in,
   input  logic              output_ready,
   output logic              module_ready,
   output logic [BITS-1:0]   pix_out,
   output logic              valid_out,
   input  logic [9:0]        pixel_x,
   input  logic [8:0]        pixel_y,
   input  logic              filter_enable,
   input  logic              filter_mode,
   input  logic [7:0]        BPM_estimate,
   input  logic [BITS-1:0]   pulse_amplitude,
   output logic [BITS-1:0]   bpm_brightness_gain,
   output logic [BITS-1:0]   env_brightness_gain,
   output logic [3*BITS-1:0] bpm_brightness_mult,
   output logic [BITS-1:0]   brightness_gain
);

   // 4 ms is 1/250 of a second
   localparam int TICK_N = CLK_HZ / 250;
   localparam logic [BITS-1:0] GAIN_MAX = {BITS{1'b1}};

   logic [BITS-1:0]   env_gain_s;
   logic              unused_tick_4ms_s;
   logic [8:0]        bpm_sum_s;
   logic [2*BITS-1:0] env_prod_s;
   logic [15:0]       gain_ext_s;
   logic [15:0]       half_diff_s;
   logic [BITS-1:0]   gain_temp_s;
   logic [2*BITS-1:0] pix_prod_s;
   logic [2*BITS-1:0] temp_pix_out_s;
   logic [BITS-1:0]   pix_next_s;
   logic              accept_s;

   adsr_envelope #(
      .BITS          (BITS),
      .TICK_N        (TICK_N),
      .ATTACK_STEP   (ATTACK_STEP),
      .DECAY_STEP    (DECAY_STEP),
      .SUSTAIN_LEVEL (SUSTAIN_LEVEL),
      .SUSTAIN_TICKS (SUSTAIN_TICKS),
      .RELEASE_STEP  (RELEASE_STEP)
   ) u_env (
      .clk      (clk),
      .reset    (reset),
      .enable   (filter_enable),
      .bpm      (BPM_estimate),
      .env_gain (env_gain_s),
      .tick_4ms (unused_tick_4ms_s)
   );

   assign module_ready = output_ready || !valid_out;
   assign accept_s     = valid_in && module_ready;

   // Gain chain: BPM boost, envelope scaling, and their product
   always_comb begin
      bpm_sum_s           = {1'b0, BPM_estimate} + {3'b000, BPM_estimate[7:2]};
      bpm_brightness_gain = bpm_sum_s[8] ? GAIN_MAX : BITS'(bpm_sum_s[7:0]);
      env_prod_s          = (2*BITS)'(env_gain_s) * (2*BITS)'(pulse_amplitude);
      env_brightness_gain = BITS'(env_prod_s >> BITS);
      bpm_brightness_mult = (3*BITS)'(env_prod_s) * (3*BITS)'(bpm_brightness_gain);
      brightness_gain     = bpm_brightness_mult[3*BITS-1:2*BITS];
   end

   // Pixel math: radial falloff, brighten by gain/256, saturate
   always_comb begin
      gain_ext_s  = 16'(brightness_gain);
      half_diff_s = 16'(manhattan_dist(pixel_x, pixel_y) >> 1);
      if (!filter_mode) begin
         gain_temp_s = brightness_gain;
      end else if (gain_ext_s > half_diff_s) begin
         gain_temp_s = BITS'(gain_ext_s - half_diff_s);
      end else begin
         gain_temp_s = {BITS{1'b0}};
      end
      pix_prod_s     = (2*BITS)'(pix_in) * (2*BITS)'(gain_temp_s);
      temp_pix_out_s = (2*BITS)'(pix_in) + (pix_prod_s >> BITS);
      if (!filter_enable) begin
         pix_next_s = pix_in;
      end else if (temp_pix_out_s > (2*BITS)'(GAIN_MAX)) begin
         pix_next_s = GAIN_MAX;
      end else begin
         pix_next_s = BITS'(temp_pix_out_s);
      end
   end

   // Single output stage: load on accept, drop valid once drained, hold on stall
   always_ff @(posedge clk) begin
      if (reset) begin
         pix_out   <= {BITS{1'b0}};
         valid_out <= 1'b0;
      end else if (accept_s) begin
         pix_out   <= pix_next_s;
         valid_out <= 1'b1;
      end else if (output_ready) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adsr_pixel_filter.sv
// -----------------------------------------------------------------------------
// tb_adsr_pixel_filter
// Directed bench. CLK_HZ is lowered to 1000 so one envelope tick is 4 cycles;
// all envelope expectations are counted in ticks, which is rate independent.
// -----------------------------------------------------------------------------
module tb_adsr_pixel_filter;
   import adsr_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pix_in;
   logic        valid_in;
   logic        output_ready;
   logic        module_ready;
   logic [7:0]  pix_out;
   logic        valid_out;
   logic [9:0]  pixel_x;
   logic [8:0]  pixel_y;
   logic        filter_enable;
   logic        filter_mode;
   logic [7:0]  BPM_estimate;
   logic [7:0]  pulse_amplitude;
   logic [7:0]  bpm_brightness_gain;
   logic [7:0]  env_brightness_gain;
   logic [23:0] bpm_brightness_mult;
   logic [7:0]  brightness_gain;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int t0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   adsr_pixel_filter #(.CLK_HZ(1000)) dut (
      .clk                 (clk),
      .reset               (reset),
      .pix_in              (pix_in),
      .valid_in            (valid_in),
      .output_ready        (output_ready),
      .module_ready        (module_ready),
      .pix_out             (pix_out),
      .valid_out           (valid_out),
      .pixel_x             (pixel_x),
      .pixel_y             (pixel_y),
      .filter_enable       (filter_enable),
      .filter_mode         (filter_mode),
      .BPM_estimate        (BPM_estimate),
      .pulse_amplitude     (pulse_amplitude),
      .bpm_brightness_gain (bpm_brightness_gain),
      .env_brightness_gain (env_brightness_gain),
      .bpm_brightness_mult (bpm_brightness_mult),
      .brightness_gain     (brightness_gain)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Returns at the falling edge just after the n-th envelope update
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         while (dut.u_env.tick_4ms !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 50) begin
            total++;
            $error("FAIL tick_timeout: observed no tick expected tick within 50 cycles");
         end
         @(negedge clk);
      end
   endtask

   task automatic check_env(input string tag, input adsr_state_t st, input logic [7:0] g);
      check({tag, "_state"}, 32'(dut.u_env.state_r), 32'(st));
      check({tag, "_env"}, 32'(dut.u_env.env_gain), 32'(g));
   endtask

   initial begin
      reset = 1'b1; pix_in = 8'd0; valid_in = 1'b0; output_ready = 1'b1;
      pixel_x = 10'd0; pixel_y = 9'd0; filter_enable = 1'b0; filter_mode = 1'b0;
      BPM_estimate = 8'd100; pulse_amplitude = 8'd128;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_pix_out", 32'(pix_out), 32'd0);
      check("rst_module_ready", 32'(module_ready), 32'd1);
      check_env("rst", ST_IDLE, 8'd0);

      // Fresh start with the envelope enabled, BPM 100, amp 128
      filter_enable = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_ticks(1);
      t0 = cyc;
      wait_ticks(1);
      check("tick_period", 32'(cyc - t0), 32'd4);
      wait_ticks(147);
      check_env("tick149", ST_IDLE, 8'd0);
      wait_ticks(1);
      check_env("beat150", ST_ATTACK, 8'd0);
      wait_ticks(7);
      check_env("attack7", ST_ATTACK, 8'd224);
      wait_ticks(1);
      check_env("attack8", ST_DECAY, 8'd255);

      // Gain chain and pixel path while env_gain = 255
      check("bpm_gain_100", 32'(bpm_brightness_gain), 32'd125);
      check("env_gain_128", 32'(env_brightness_gain), 32'd127);
      check("mult_100_128", 32'(bpm_brightness_mult), 32'd4_080_000);
      check("bright_100_128", 32'(brightness_gain), 32'd62);
      pix_in = 8'd127; valid_in = 1'b1;
      @(negedge clk);
      check("pix_mode0", 32'(pix_out), 32'd157);
      check("valid_mode0", 32'(valid_out), 32'd1);
      filter_mode = 1'b1; pixel_x = 10'd520; pixel_y = 9'd240; pix_in = 8'd200;
      @(negedge clk);
      check("pix_radial_far", 32'(pix_out), 32'd200);
      pixel_x = 10'd330; pixel_y = 9'd245;
      @(negedge clk);
      check("pix_radial_near", 32'(pix_out), 32'd242);
      valid_in = 1'b0; filter_mode = 1'b0; pixel_x = 10'd0; pixel_y = 9'd0;

      wait_ticks(15);
      check_env("decay15", ST_DECAY, 8'd135);
      wait_ticks(1);
      check_env("decay16", ST_SUSTAIN, 8'd128);
      wait_ticks(9);
      check_env("sustain9", ST_SUSTAIN, 8'd128);
      wait_ticks(1);
      check_env("sustain10", ST_RELEASE, 8'd128);
      wait_ticks(31);
      check_env("release31", ST_RELEASE, 8'd4);
      wait_ticks(1);
      check_env("release32", ST_IDLE, 8'd0);

      // Accumulator holds 6600 here; at 180 BPM the next beat is 47 ticks away
      BPM_estimate = 8'd180; pulse_amplitude = 8'd255;
      wait_ticks(46);
      check_env("bpm180_pre", ST_IDLE, 8'd0);
      wait_ticks(1);
      check_env("bpm180_beat", ST_ATTACK, 8'd0);
      wait_ticks(8);
      check_env("bpm180_peak", ST_DECAY, 8'd255);
      check("env_gain_255", 32'(env_brightness_gain), 32'd254);
      check("bpm_gain_180", 32'(bpm_brightness_gain), 32'd225);
      check("mult_180_255", 32'(bpm_brightness_mult), 32'd14_630_625);
      check("bright_180_255", 32'(brightness_gain), 32'd223);
      // Accumulator 60 after that beat, so the following one is 83 ticks later
      wait_ticks(74);
      check_env("bpm180_gap82", ST_IDLE, 8'd0);
      wait_ticks(1);
      check_env("bpm180_gap83", ST_ATTACK, 8'd0);

      // Pass-through and back-pressure with the filter disabled
      filter_enable = 1'b0; pix_in = 8'd90; valid_in = 1'b1;
      @(negedge clk);
      check_env("disabled", ST_IDLE, 8'd0);
      check("pix_bypass", 32'(pix_out), 32'd90);
      check("bright_disabled", 32'(brightness_gain), 32'd0);
      output_ready = 1'b0; pix_in = 8'd33;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_pix", 32'(pix_out), 32'd90);
         check("stall_valid", 32'(valid_out), 32'd1);
         check("stall_ready", 32'(module_ready), 32'd0);
      end
      output_ready = 1'b1; valid_in = 1'b0;
      @(negedge clk);
      check("drain_valid", 32'(valid_out), 32'd0);
      check("drain_ready", 32'(module_ready), 32'd1);

      // Reset mid-ATTACK at 200 BPM (beat every 75 ticks)
      filter_enable = 1'b1; BPM_estimate = 8'd200; pulse_amplitude = 8'd128;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_ticks(74);
      check_env("bpm200_pre", ST_IDLE, 8'd0);
      wait_ticks(1);
      check_env("bpm200_beat", ST_ATTACK, 8'd0);
      wait_ticks(2);
      check_env("bpm200_attack2", ST_ATTACK, 8'd64);
      reset = 1'b1;
      @(negedge clk);
      check_env("mid_attack_rst", ST_IDLE, 8'd0);
      check("mid_rst_gain", 32'(env_brightness_gain), 32'd0);
      reset = 1'b0;
      wait_ticks(74);
      check_env("fresh_acc_pre", ST_IDLE, 8'd0);
      wait_ticks(1);
      check_env("fresh_acc_beat", ST_ATTACK, 8'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
